// File: rtl/w0rm_synchro.sv
// w0rm_synchro: valid/ready register slice, either a plain pipeline register
// (combinational input_ready) or a two-entry skid buffer (registered input_ready).
module w0rm_synchro #(
    parameter int DATA_WIDTH = 8,
    parameter bit SYNC_READY = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  input_valid,
    output logic                  input_ready,
    input  logic [DATA_WIDTH-1:0] input_data,
    output logic                  output_valid,
    input  logic                  output_ready,
    output logic [DATA_WIDTH-1:0] output_data
);
    generate
        if (!SYNC_READY) begin : g_comb
            assign input_ready = !reset && (output_ready || !output_valid);
            always_ff @(posedge clk) begin
                if (reset) begin
                    output_valid <= 1'b0;
                    output_data  <= '0;
                end else if (input_valid && input_ready) begin
                    output_data  <= input_data;
                    output_valid <= 1'b1;
                end else if (output_ready) begin
                    output_valid <= 1'b0;
                end
            end
        end else begin : g_skid
            typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
            state_t                state;
            logic                  rdy_q;
            logic [DATA_WIDTH-1:0] skid;
            // rdy_q stays high in ONE, so a valid input there is always a transfer
            assign input_ready = rdy_q && !reset;
            always_ff @(posedge clk) begin
                if (reset) begin
                    state        <= EMPTY;
                    rdy_q        <= 1'b0;
                    output_valid <= 1'b0;
                    output_data  <= '0;
                    skid         <= '0;
                end else begin
                    case (state)
                        EMPTY: begin
                            rdy_q <= 1'b1;
                            if (input_valid && rdy_q) begin
                                output_data  <= input_data;
                                output_valid <= 1'b1;
                                state        <= ONE;
                            end
                        end
                        ONE: begin
                            if (input_valid) begin
                                if (output_ready) begin
                                    output_data <= input_data;
                                end else begin
                                    skid  <= input_data;
                                    rdy_q <= 1'b0;
                                    state <= FULL;
                                end
                            end else if (output_ready) begin
                                output_valid <= 1'b0;
                                state        <= EMPTY;
                            end
                        end
                        FULL: begin
                            if (output_ready) begin
                                output_data <= skid;
                                rdy_q       <= 1'b1;
                                state       <= ONE;
                            end
                        end
                        default: state <= EMPTY;
                    endcase
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_w0rm_synchro.sv
// tb_w0rm_synchro: both ready modes side by side, each checked against a
// FIFO occupancy model of the slice.
module tb_w0rm_synchro;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iv[2], ir[2], ov[2], ordy[2];
    logic [7:0] id[2], od[2];

    always #5 clk = ~clk;

    w0rm_synchro #(.DATA_WIDTH(8), .SYNC_READY(1'b0)) u0 (
        .clk(clk), .reset(rst), .input_valid(iv[0]), .input_ready(ir[0]), .input_data(id[0]),
        .output_valid(ov[0]), .output_ready(ordy[0]), .output_data(od[0]));
    w0rm_synchro #(.DATA_WIDTH(8), .SYNC_READY(1'b1)) u1 (
        .clk(clk), .reset(rst), .input_valid(iv[1]), .input_ready(ir[1]), .input_data(id[1]),
        .output_valid(ov[1]), .output_ready(ordy[1]), .output_data(od[1]));

    int         total = 0, bad = 0;
    logic [7:0] mem[2][256];
    int         wr[2], rd[2];
    logic       zf[2], ixf[2], oxf[2];
    logic       rstp = 1'b1;
    logic [7:0] src[2][64];
    int         sp[2], sn[2], rd0[2];

    task automatic chk(input string tag, input int m, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s dut%0d got=%0h exp=%0h t=%0t", tag, m, got, exp, $time);
        end
    endtask

    // called at the falling edge with inputs already driven
    task automatic tick();
        #1;
        for (int m = 0; m < 2; m++) begin
            int   held;
            logic exp_ir;
            held   = wr[m] - rd[m];
            exp_ir = !rst && !(m == 1 && rstp) && (m == 0 ? (ordy[m] || held == 0) : held < 2);
            chk("in_ready", m, 32'(ir[m]), 32'(exp_ir));
            chk("out_valid", m, 32'(ov[m]), 32'(held != 0));
            if (held != 0) chk("out_data", m, 32'(od[m]), 32'(mem[m][rd[m] % 256]));
            else if (zf[m]) chk("out_zero", m, 32'(od[m]), 32'h0);
            if (m == 1) chk("held_le2", m, 32'(held <= 2), 32'h1);
            ixf[m] = iv[m] && exp_ir;
            oxf[m] = !rst && held != 0 && ordy[m];
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                rd[m] = wr[m];
                zf[m] = 1'b1;
            end else begin
                if (oxf[m]) rd[m]++;
                if (ixf[m]) begin
                    mem[m][wr[m] % 256] = id[m];
                    wr[m]++;
                    zf[m] = 1'b0;
                end
            end
        end
        rstp = rst;
        @(negedge clk);
    endtask

    task automatic load(input logic [7:0] base, input int n);
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < n; i++) src[m][i] = base + 8'(i);
            sp[m]  = 0;
            sn[m]  = n;
            rd0[m] = rd[m];
        end
    endtask

    task automatic run(input int n, input int pv, input int pr);
        repeat (n) begin
            for (int m = 0; m < 2; m++) begin
                iv[m]   = sp[m] < sn[m] && $urandom_range(99) < pv;
                id[m]   = iv[m] ? src[m][sp[m]] : 8'($urandom);
                ordy[m] = $urandom_range(99) < pr;
            end
            tick();
            for (int m = 0; m < 2; m++) if (ixf[m]) sp[m]++;
        end
    endtask

    task automatic delivered(input string tag, input int n);
        for (int m = 0; m < 2; m++) chk(tag, m, 32'(rd[m] - rd0[m]), 32'(n));
    endtask

    initial begin
        logic [4:0] gv;
        logic [7:0] gd[5];
        void'($urandom(32'h5eed));
        for (int m = 0; m < 2; m++) begin
            wr[m] = 0; rd[m] = 0; zf[m] = 1'b0; sp[m] = 0; sn[m] = 0;
            iv[m] = 1'b0; id[m] = 8'h0; ordy[m] = 1'b1;
        end
        @(negedge clk);
        repeat (10) tick();
        rst = 1'b0;
        // continuous stream, full throughput
        load(8'h01, 16);
        run(20, 100, 100);
        delivered("stream", 16);
        // valid gaps
        gv = 5'b01101;
        gd = '{8'hA5, 8'hFF, 8'h3C, 8'h7E, 8'h00};
        for (int m = 0; m < 2; m++) rd0[m] = rd[m];
        for (int k = 0; k < 5; k++) begin
            for (int m = 0; m < 2; m++) begin
                iv[m] = gv[k]; id[m] = gd[k]; ordy[m] = 1'b1;
            end
            tick();
        end
        for (int m = 0; m < 2; m++) iv[m] = 1'b0;
        tick();
        tick();
        delivered("gaps", 3);
        // reset after 0x05 was accepted
        load(8'h01, 8);
        for (int k = 0; k < 20 && sp[0] < 5; k++) run(1, 100, 100);
        chk("pre_reset", 0, 32'(sp[0]), 32'd5);
        rst = 1'b1;
        for (int m = 0; m < 2; m++) begin
            iv[m] = 1'b1; id[m] = 8'h06;
        end
        tick();
        rst = 1'b0;
        for (int m = 0; m < 2; m++) iv[m] = 1'b0;
        tick();
        load(8'h41, 4);
        run(8, 100, 100);
        delivered("restart", 4);
        // backpressure while 0x11 is held
        load(8'h11, 2);
        run(1, 100, 100);
        run(3, 100, 0);
        chk("bp_hold", 0, 32'(od[0]), 32'h11);
        chk("bp_wait", 0, 32'(sp[0]), 32'd1);
        run(4, 100, 100);
        delivered("bp_done", 2);
        // skid buffer under random backpressure
        load(8'h20, 16);
        run(80, 100, 50);
        run(10, 0, 100);
        delivered("skid_rand", 16);
        // mixed random traffic
        load(8'h80, 64);
        run(400, 70, 60);
        run(10, 0, 100);
        delivered("mixed", 64);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
